// File: rtl/rt_pkg.sv
// Shared ray-tracing definitions: Q16.16 vector widths, the intersection FSM
// state encoding and the fixed-point multiply used by the vector units.
package rt_pkg;

    localparam int VEC_W  = 96;
    localparam int COMP_W = 32;
    localparam int FRAC   = 16;

    localparam logic [COMP_W-1:0] ONE         = 32'h0001_0000;
    localparam logic [COMP_W-1:0] EPS_DEFAULT = 32'h0000_0010;

    typedef enum logic [3:0] {
        IDLE,
        EDGE,
        CROSS_P,
        DOT_DET,
        CROSS_Q,
        DOT_U,
        DOT_V,
        DOT_T,
        DECIDE,
        DONE
    } state_t;

    // Full 64-bit signed product rescaled by FRAC; the kept slice equals
    // an arithmetic right shift truncated back to one component.
    function automatic logic [COMP_W-1:0] fx_mul(input logic [COMP_W-1:0] a,
                                                 input logic [COMP_W-1:0] b);
        logic signed [2*COMP_W-1:0] sa;
        logic signed [2*COMP_W-1:0] sb;
        logic signed [2*COMP_W-1:0] prod;
        sa   = {{COMP_W{a[COMP_W-1]}}, a};
        sb   = {{COMP_W{b[COMP_W-1]}}, b};
        prod = sa * sb;
        return prod[FRAC +: COMP_W];
    endfunction

endpackage

// File: rtl/vec_cross.sv
// Combinational Q16.16 cross product c = a x b.
module vec_cross
    import rt_pkg::*;
(
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    output logic [VEC_W-1:0] c
);

    logic [COMP_W-1:0] ax, ay, az, bx, by, bz;
    logic [COMP_W-1:0] cx, cy, cz;

    assign ax = a[0*COMP_W +: COMP_W];
    assign ay = a[1*COMP_W +: COMP_W];
    assign az = a[2*COMP_W +: COMP_W];
    assign bx = b[0*COMP_W +: COMP_W];
    assign by = b[1*COMP_W +: COMP_W];
    assign bz = b[2*COMP_W +: COMP_W];

    // Each product is rescaled on its own before the wrapping subtract.
    assign cx = fx_mul(ay, bz) - fx_mul(az, by);
    assign cy = fx_mul(az, bx) - fx_mul(ax, bz);
    assign cz = fx_mul(ax, by) - fx_mul(ay, bx);

    assign c = {cz, cy, cx};

endmodule

// File: rtl/vec_dot.sv
// Combinational Q16.16 dot product; the three-term sum wraps at 32 bits.
module vec_dot
    import rt_pkg::*;
(
    input  logic [VEC_W-1:0]  a,
    input  logic [VEC_W-1:0]  b,
    output logic [COMP_W-1:0] s
);

    assign s = fx_mul(a[0*COMP_W +: COMP_W], b[0*COMP_W +: COMP_W])
             + fx_mul(a[1*COMP_W +: COMP_W], b[1*COMP_W +: COMP_W])
             + fx_mul(a[2*COMP_W +: COMP_W], b[2*COMP_W +: COMP_W]);

endmodule

// File: rtl/vec_sub.sv
// Component-wise vec3 subtraction d = a - b, each lane wrapping at 32 bits.
module vec_sub
    import rt_pkg::*;
(
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    output logic [VEC_W-1:0] d
);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            d[i*COMP_W +: COMP_W] = a[i*COMP_W +: COMP_W] - b[i*COMP_W +: COMP_W];
        end
    end

endmodule

// File: rtl/mt_seq.sv
// Sequential Moller-Trumbore ray/triangle test: one shared cross unit and one
// shared dot unit walked through by an FSM, one vector operation per cycle.
module mt_seq
    import rt_pkg::*;
#(
    parameter logic [COMP_W-1:0] EPS = EPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  ray_orig,
    input  logic [VEC_W-1:0]  ray_dir,
    input  logic [VEC_W-1:0]  v0,
    input  logic [VEC_W-1:0]  v1,
    input  logic [VEC_W-1:0]  v2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              hit,
    output logic [COMP_W-1:0] t_num,
    output logic [COMP_W-1:0] u_num,
    output logic [COMP_W-1:0] v_num,
    output logic [COMP_W-1:0] det_abs
);

    state_t state, state_nx;

    logic [VEC_W-1:0]  orig_r, dir_r, v0_r, v1_r, v2_r;
    logic [VEC_W-1:0]  e1_r, e2_r, tv_r, p_r, q_r;
    logic [COMP_W-1:0] det_r, u_r, v_r, t_r;
    logic              dec_ph;

    logic [VEC_W-1:0]  e1_w, e2_w, tv_w;
    logic [VEC_W-1:0]  cross_a, cross_b, cross_c;
    logic [VEC_W-1:0]  dot_a, dot_b;
    logic [COMP_W-1:0] dot_s, dot_mag;

    logic              det_neg, det_small;
    logic [COMP_W-1:0] det_mag, u_n, v_n, t_n;
    logic              accept;

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    vec_sub sub_e1 (.a(v1_r),   .b(v0_r), .d(e1_w));
    vec_sub sub_e2 (.a(v2_r),   .b(v0_r), .d(e2_w));
    vec_sub sub_t  (.a(orig_r), .b(v0_r), .d(tv_w));

    vec_cross u_cross (.a(cross_a), .b(cross_b), .c(cross_c));
    vec_dot   u_dot   (.a(dot_a),   .b(dot_b),   .s(dot_s));

    // Operand steering for the two shared units; idle cycles feed zeros.
    always_comb begin
        cross_a = '0;
        cross_b = '0;
        dot_a   = '0;
        dot_b   = '0;
        case (state)
            CROSS_P: begin cross_a = dir_r; cross_b = e2_r; end
            CROSS_Q: begin cross_a = tv_r;  cross_b = e1_r; end
            DOT_DET: begin dot_a = e1_r;  dot_b = p_r; end
            DOT_U:   begin dot_a = tv_r;  dot_b = p_r; end
            DOT_V:   begin dot_a = dir_r; dot_b = q_r; end
            DOT_T:   begin dot_a = e2_r;  dot_b = q_r; end
            default: ;
        endcase
    end

    assign dot_mag   = dot_s[COMP_W-1] ? -dot_s : dot_s;
    assign det_neg   = det_r[COMP_W-1];
    assign det_mag   = det_neg ? -det_r : det_r;
    assign det_small = (det_mag < EPS);
    assign u_n       = det_neg ? -u_r : u_r;
    assign v_n       = det_neg ? -v_r : v_r;
    assign t_n       = det_neg ? -t_r : t_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DECIDE dwells two cycles: sign normalization first, then the hit test
    // on the registered normalized values.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = EDGE;
            EDGE:    state_nx = CROSS_P;
            CROSS_P: state_nx = DOT_DET;
            DOT_DET: state_nx = (dot_mag < EPS) ? DECIDE : CROSS_Q;
            CROSS_Q: state_nx = DOT_U;
            DOT_U:   state_nx = DOT_V;
            DOT_V:   state_nx = DOT_T;
            DOT_T:   state_nx = DECIDE;
            DECIDE:  if (dec_ph) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            orig_r  <= '0;
            dir_r   <= '0;
            v0_r    <= '0;
            v1_r    <= '0;
            v2_r    <= '0;
            e1_r    <= '0;
            e2_r    <= '0;
            tv_r    <= '0;
            p_r     <= '0;
            q_r     <= '0;
            det_r   <= '0;
            u_r     <= '0;
            v_r     <= '0;
            t_r     <= '0;
            dec_ph  <= 1'b0;
            hit     <= 1'b0;
            t_num   <= '0;
            u_num   <= '0;
            v_num   <= '0;
            det_abs <= '0;
        end else begin
            if (accept) begin
                orig_r <= ray_orig;
                dir_r  <= ray_dir;
                v0_r   <= v0;
                v1_r   <= v1;
                v2_r   <= v2;
            end
            case (state)
                EDGE: begin
                    e1_r <= e1_w;
                    e2_r <= e2_w;
                    tv_r <= tv_w;
                end
                CROSS_P: p_r   <= cross_c;
                DOT_DET: det_r <= dot_s;
                CROSS_Q: q_r   <= cross_c;
                DOT_U:   u_r   <= dot_s;
                DOT_V:   v_r   <= dot_s;
                DOT_T:   t_r   <= dot_s;
                DECIDE: begin
                    dec_ph <= ~dec_ph;
                    if (!dec_ph) begin
                        hit <= 1'b0;
                        if (det_small) begin
                            t_num   <= '0;
                            u_num   <= '0;
                            v_num   <= '0;
                            det_abs <= '0;
                        end else begin
                            t_num   <= t_n;
                            u_num   <= u_n;
                            v_num   <= v_n;
                            det_abs <= det_mag;
                        end
                    end else begin
                        hit <= !det_small
                             && !u_num[COMP_W-1]
                             && !v_num[COMP_W-1]
                             && (({1'b0, u_num} + {1'b0, v_num}) <= {1'b0, det_abs})
                             && ($signed(t_num) > 0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mt_seq.sv
// Directed-vector bench for mt_seq: table of hand-computed intersections plus
// backpressure and mid-job reset sequences.
module tb_mt_seq;
    import rt_pkg::*;

    localparam logic [31:0] Z   = 32'h0000_0000;
    localparam logic [31:0] Q1  = 32'h0000_4000;
    localparam logic [31:0] H1  = 32'h0000_8000;
    localparam logic [31:0] M1  = 32'hFFFF_0000;
    localparam logic [31:0] TW  = 32'h0002_0000;
    localparam logic [31:0] F5  = 32'h0001_4000;

    typedef struct {
        logic [95:0] orig;
        logic [95:0] dir;
        logic [95:0] p0;
        logic [95:0] p1;
        logic [95:0] p2;
        logic        exp_hit;
        logic [31:0] exp_t;
        logic [31:0] exp_u;
        logic [31:0] exp_v;
        logic [31:0] exp_det;
        int          exp_lat;
    } vec_rec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] ray_orig, ray_dir, v0, v1, v2;
    logic        out_valid;
    logic        out_ready;
    logic        hit;
    logic [31:0] t_num, u_num, v_num, det_abs;

    int n_assert = 0;
    int n_fail   = 0;

    vec_rec_t vecs [9];

    mt_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ray_orig  (ray_orig),
        .ray_dir   (ray_dir),
        .v0        (v0),
        .v1        (v1),
        .v2        (v2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hit       (hit),
        .t_num     (t_num),
        .u_num     (u_num),
        .v_num     (v_num),
        .det_abs   (det_abs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return {z, y, x};
    endfunction

    function automatic vec_rec_t mk(input logic [95:0] o, input logic [95:0] d,
                                    input logic [95:0] a, input logic [95:0] b,
                                    input logic [95:0] c, input logic h,
                                    input logic [31:0] t, input logic [31:0] u,
                                    input logic [31:0] v, input logic [31:0] dt,
                                    input int l);
        vec_rec_t r;
        r.orig = o; r.dir = d; r.p0 = a; r.p1 = b; r.p2 = c;
        r.exp_hit = h; r.exp_t = t; r.exp_u = u; r.exp_v = v; r.exp_det = dt;
        r.exp_lat = l;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_job(input vec_rec_t r);
        ray_orig = r.orig;
        ray_dir  = r.dir;
        v0       = r.p0;
        v1       = r.p1;
        v2       = r.p2;
        in_valid = 1'b1;
    endtask

    task automatic scramble_inputs();
        in_valid = 1'b0;
        ray_orig = {$urandom, $urandom, $urandom};
        ray_dir  = {$urandom, $urandom, $urandom};
        v0       = {$urandom, $urandom, $urandom};
        v1       = {$urandom, $urandom, $urandom};
        v2       = {$urandom, $urandom, $urandom};
    endtask

    // Offers one job, then counts edges after the accepting edge until out_valid.
    task automatic apply_stimulus(input vec_rec_t r, output int lat);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        drive_job(r);
        @(posedge clk); #1;
        scramble_inputs();
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_output(input vec_rec_t r, input int lat, input string tag);
        check({tag, ".latency"}, 32'(lat), 32'(r.exp_lat));
        check({tag, ".hit"},     {31'b0, hit}, {31'b0, r.exp_hit});
        check({tag, ".t_num"},   t_num,   r.exp_t);
        check({tag, ".u_num"},   u_num,   r.exp_u);
        check({tag, ".v_num"},   v_num,   r.exp_v);
        check({tag, ".det_abs"}, det_abs, r.exp_det);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".in_ready_after_release"},  {31'b0, in_ready},  32'd1);
        check({tag, ".out_valid_after_release"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int spurious;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ray_orig  = '0;
        ray_dir   = '0;
        v0        = '0;
        v1        = '0;
        v2        = '0;

        vecs[0] = mk(v3(Q1, Q1, M1), v3(Z, Z, ONE), v3(Z, Z, Z), v3(ONE, Z, Z), v3(Z, ONE, Z),
                     1'b1, ONE, Q1, Q1, ONE, 9);
        vecs[1] = mk(v3(ONE, ONE, M1), v3(Z, Z, ONE), v3(Z, Z, Z), v3(ONE, Z, Z), v3(Z, ONE, Z),
                     1'b0, ONE, ONE, ONE, ONE, 9);
        vecs[2] = mk(v3(Q1, Q1, ONE), v3(Z, Z, ONE), v3(Z, Z, Z), v3(ONE, Z, Z), v3(Z, ONE, Z),
                     1'b0, M1, Q1, Q1, ONE, 9);
        vecs[3] = mk(v3(Q1, Q1, M1), v3(ONE, Z, Z), v3(Z, Z, Z), v3(ONE, Z, Z), v3(Z, ONE, Z),
                     1'b0, Z, Z, Z, Z, 5);
        vecs[4] = mk(v3(Q1, Q1, M1), v3(Z, Z, ONE), v3(Z, Z, Z), v3(Z, ONE, Z), v3(ONE, Z, Z),
                     1'b1, ONE, Q1, Q1, ONE, 9);
        vecs[5] = mk(v3(Q1, Q1, M1), v3(Z, Z, ONE), v3(Z, Z, Z), v3(32'h8, Z, Z), v3(Z, ONE, Z),
                     1'b0, Z, Z, Z, Z, 5);
        vecs[6] = mk(v3(Q1, Q1, M1), v3(Z, Z, ONE), v3(Z, Z, Z), v3(32'h10, Z, Z), v3(Z, ONE, Z),
                     1'b0, 32'h10, Q1, 32'h4, 32'h10, 9);
        vecs[7] = mk(v3(F5, F5, Z), v3(Z, Z, ONE), v3(ONE, ONE, ONE), v3(TW, ONE, ONE),
                     v3(ONE, TW, ONE), 1'b1, ONE, Q1, Q1, ONE, 9);
        vecs[8] = mk(v3(H1, H1, M1), v3(Z, Z, ONE), v3(Z, Z, Z), v3(ONE, Z, Z), v3(Z, ONE, Z),
                     1'b1, ONE, H1, H1, ONE, 9);

        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", {31'b0, out_valid}, 32'd0);
        check("reset.hit",       {31'b0, hit},       32'd0);
        check("reset.t_num",     t_num,   32'd0);
        check("reset.u_num",     u_num,   32'd0);
        check("reset.v_num",     v_num,   32'd0);
        check("reset.det_abs",   det_abs, 32'd0);
        check("reset.in_ready",  {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i], lat);
            check_output(vecs[i], lat, $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Held result must not move while the consumer stalls.
        apply_stimulus(vecs[0], lat);
        check_output(vecs[0], lat, "bp");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp.hold%0d.out_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp.hold%0d.in_ready", k),  {31'b0, in_ready},  32'd0);
            check($sformatf("bp.hold%0d.hit", k),       {31'b0, hit},       32'd1);
            check($sformatf("bp.hold%0d.t_num", k),     t_num,   ONE);
            check($sformatf("bp.hold%0d.u_num", k),     u_num,   Q1);
            check($sformatf("bp.hold%0d.v_num", k),     v_num,   Q1);
            check($sformatf("bp.hold%0d.det_abs", k),   det_abs, ONE);
        end
        release_result("bp");
        apply_stimulus(vecs[1], lat);
        check_output(vecs[1], lat, "b2b");
        release_result("b2b");

        // Reset pulse while the FSM sits in CROSS_Q drops the job.
        drive_job(vecs[0]);
        @(posedge clk); #1;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst.in_ready",  {31'b0, in_ready},  32'd1);
        spurious = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check("midrst.no_result", 32'(spurious), 32'd0);
        apply_stimulus(vecs[2], lat);
        check_output(vecs[2], lat, "after_rst");
        release_result("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
